// File: rtl/led_status_pager.sv
// LED status pager: one-hot FSM state on LEDR[3:0], paged and blinking data field above it.
module led_status_pager #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LED_W     = 10,
    parameter int unsigned PAGE_DIV  = 50_000_000,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        state,
    input  logic [DATA_W-1:0] A_registered,
    input  logic [DATA_W-1:0] B_registered,
    input  logic [2:0]        OP_registered,
    input  logic [DATA_W-1:0] result,
    input  logic              err,
    input  logic              page_next,
    input  logic              auto_page,
    output logic [LED_W-1:0]  LEDR
);

    localparam int unsigned DF      = LED_W - 4;
    localparam int unsigned NPAGES  = (DATA_W + DF - 1) / DF;
    localparam int unsigned SRC_W   = NPAGES * DF;
    localparam int unsigned PAGE_W  = (NPAGES > 1) ? $clog2(NPAGES) : 1;
    localparam int unsigned TMR_W   = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam int unsigned BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [1:0]        state_q;
    logic [PAGE_W-1:0] page_q;
    logic [TMR_W-1:0]  page_tmr_q;
    logic [BLK_W-1:0]  blink_cnt_q;
    logic              blink_ph_q;
    logic              prev_page_next_q;

    logic [1:0]        state_d;
    logic [PAGE_W-1:0] page_d;
    logic [TMR_W-1:0]  page_tmr_d;
    logic [BLK_W-1:0]  blink_cnt_d;
    logic              blink_ph_d;
    logic [LED_W-1:0]  ledr_d;

    logic              state_chg;
    logic              edge_adv;
    logic              tmr_exp;
    logic              advance;
    logic [DATA_W-1:0] src;
    logic [SRC_W-1:0]  src_ext;
    logic [DF-1:0]     field;
    logic [3:0]        onehot;

    // Register update; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= 2'b00;
            page_q           <= '0;
            page_tmr_q       <= '0;
            blink_cnt_q      <= '0;
            blink_ph_q       <= 1'b1;
            prev_page_next_q <= 1'b0;
            LEDR             <= '0;
        end else begin
            state_q          <= state_d;
            page_q           <= page_d;
            page_tmr_q       <= page_tmr_d;
            blink_cnt_q      <= blink_cnt_d;
            blink_ph_q       <= blink_ph_d;
            prev_page_next_q <= page_next;
            LEDR             <= ledr_d;
        end
    end

    // Next page, timers, blink phase and the LED word built from post-update page/phase.
    always_comb begin
        state_d     = state;
        page_d      = page_q;
        page_tmr_d  = page_tmr_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        src         = '0;
        field       = '0;
        onehot      = '0;

        state_chg = (state != state_q);
        edge_adv  = page_next & ~prev_page_next_q;
        tmr_exp   = auto_page && (page_tmr_q == TMR_W'(PAGE_DIV - 1));
        advance   = edge_adv | tmr_exp;

        // State change wins over any advance; two advance sources still step once.
        if (state_chg) begin
            page_d = '0;
        end else if (advance) begin
            if (page_q == PAGE_W'(NPAGES - 1)) begin
                page_d = '0;
            end else begin
                page_d = page_q + PAGE_W'(1);
            end
        end

        if (!auto_page || advance || state_chg) begin
            page_tmr_d = '0;
        end else begin
            page_tmr_d = page_tmr_q + TMR_W'(1);
        end

        if (!err) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end

        case (state)
            2'b00:   src = DATA_W'(OP_registered);
            2'b01:   src = A_registered;
            2'b10:   src = B_registered;
            default: src = result;
        endcase

        // Bits above DATA_W come from the zero extension.
        src_ext = SRC_W'(src);
        for (int unsigned p = 0; p < NPAGES; p++) begin
            if (page_d == PAGE_W'(p)) begin
                field = src_ext[p*DF +: DF];
            end
        end
        if (!blink_ph_d) begin
            field = '0;
        end

        onehot[state] = 1'b1;
        ledr_d = {field, onehot};
    end

endmodule

// File: tb/tb_led_status_pager.sv
// Directed bench for led_status_pager with small dividers.
module tb_led_status_pager;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LED_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        state;
    logic [DATA_W-1:0] a_reg, b_reg, result;
    logic [2:0]        op_reg;
    logic              err, page_next, auto_page;
    logic [LED_W-1:0]  ledr;

    int n_vec  = 0;
    int n_fail = 0;

    led_status_pager #(
        .DATA_W(DATA_W), .LED_W(LED_W), .PAGE_DIV(4), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state),
        .A_registered(a_reg), .B_registered(b_reg), .OP_registered(op_reg),
        .result(result), .err(err), .page_next(page_next), .auto_page(auto_page),
        .LEDR(ledr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LED_W-1:0] got, input logic [LED_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: LEDR=0x%03h expected 0x%03h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [LED_W-1:0] exp);
        step();
        chk(tag, ledr, exp);
    endtask

    initial begin
        rst_n = 1'b0; state = 2'b11; a_reg = 8'h5A; b_reg = 8'hA5; result = 8'hFF;
        op_reg = 3'b111; err = 1'b1; page_next = 1'b1; auto_page = 1'b1;
        for (int i = 0; i < 3; i++) step_chk("reset", 10'h000);

        // Release at page 0
        rst_n = 1'b1; state = 2'b00; op_reg = 3'b101; err = 1'b0;
        page_next = 1'b0; auto_page = 1'b0;
        step_chk("release", 10'h051);

        // Manual paging
        state = 2'b01; a_reg = 8'hB7;
        step_chk("man_p0", 10'h372);
        page_next = 1'b1; step_chk("man_p1", 10'h022);
        page_next = 1'b0; step_chk("man_p1_hold", 10'h022);
        page_next = 1'b1; step_chk("man_wrap", 10'h372);
        step_chk("man_held1", 10'h372);
        step_chk("man_held2", 10'h372);
        page_next = 1'b0;

        // Auto paging
        state = 2'b10; b_reg = 8'hC0; auto_page = 1'b1;
        for (int i = 0; i < 4; i++) step_chk("auto_p0", 10'h004);
        for (int i = 0; i < 4; i++) step_chk("auto_p1", 10'h034);
        step_chk("auto_wrap", 10'h004);
        for (int i = 0; i < 3; i++) step_chk("auto_p0b", 10'h004);
        page_next = 1'b1;
        step_chk("edge_on_expiry", 10'h034);

        // State change on page 1, timer restarts
        state = 2'b11; result = 8'h3F;
        step_chk("chg_p0", 10'h3F8);
        for (int i = 0; i < 3; i++) step_chk("chg_tmr_restart", 10'h3F8);
        step_chk("chg_auto_p1", 10'h008);

        auto_page = 1'b0; page_next = 1'b0;
        step_chk("auto_off", 10'h008);
        page_next = 1'b1; step_chk("back_p0", 10'h3F8);
        page_next = 1'b0; step_chk("steady_p0", 10'h3F8);

        // Blink
        err = 1'b1;
        step_chk("blink_on1", 10'h3F8);
        step_chk("blink_off1", 10'h008);
        step_chk("blink_off2", 10'h008);
        step_chk("blink_on2", 10'h3F8);
        step_chk("blink_on3", 10'h3F8);
        step_chk("blink_off3", 10'h008);
        err = 1'b0;
        step_chk("blink_stop", 10'h3F8);

        // Reset mid-page, mid-blink
        result = 8'hC5; page_next = 1'b1;
        step_chk("pre_rst_p1", 10'h038);
        page_next = 1'b0; err = 1'b1;
        step_chk("pre_rst_on", 10'h038);
        step_chk("pre_rst_off", 10'h008);
        rst_n = 1'b0;
        step_chk("mid_rst", 10'h000);
        rst_n = 1'b1;
        step_chk("post_rst_p0_on", 10'h058);
        step_chk("post_rst_off", 10'h008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/led_status_pager.md
LED_STATUS_PAGER -- requirements
Module: led_status_pager

Interface
REQ-001 The module SHALL have these parameters:
- DATA_W, default 8, width of A/B/result operands.
- LED_W, default 10, total LED count; LED_W >= 5.
- PAGE_DIV, default 50_000_000, clock cycles per automatic page step.
- BLINK_DIV, default 12_500_000, clock cycles per blink half-period.

REQ-002 Derived constants SHALL be DF = LED_W-4 (data-field width) and NPAGES = ceil(DATA_W/DF).

REQ-003 The module SHALL have these ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- state  input  2  FSM state being displayed.
- A_registered  input  DATA_W  registered operand A.
- B_registered  input  DATA_W  registered operand B.
- OP_registered  input  3  registered opcode.
- result  input  DATA_W  current result.
- err  input  1  error/overflow flag; level.
- page_next  input  1  manual page advance; level, rising-edge detected internally.
- auto_page  input  1  enables timed paging.
- LEDR  output  LED_W  registered LED drive.

Function
REQ-004 LEDR[3:0] SHALL be one-hot of state: bit k high iff state==k.
REQ-005 LEDR[3:0] SHALL never blink and SHALL never depend on page.
REQ-006 LEDR[LED_W-1:4] SHALL be the data field, built from a source value selected by state:
- 00: OP_registered, zero-extended.
- 01: A_registered.
- 10: B_registered.
- 11: result.
REQ-007 The data field SHALL be source bits [page*DF +: DF], LSB at LEDR[4], with bits at or above DATA_W read as 0.
REQ-008 The page register SHALL be 0..NPAGES-1; when NPAGES==1 it SHALL stay 0.
REQ-009 A page advance SHALL be raised by either of:
- a page_next rising edge (page_next==1 while prev_page_next==0);
- expiry of the page timer.
REQ-010 On an advance, page SHALL increment, wrapping NPAGES-1 -> 0.
REQ-011 A page_next edge and timer expiry on the same cycle SHALL advance the page exactly once.
REQ-012 The page timer SHALL count only while auto_page==1.
REQ-013 The page timer SHALL expire at PAGE_DIV-1 and then return to 0.
REQ-014 The page timer SHALL clear to 0 on any of:
- auto_page==0;
- any advance;
- a state change.
REQ-015 A state change (state != internal state_q) SHALL set page to 0 and clear the page timer.
REQ-016 A state change SHALL take priority over any advance on the same cycle.
REQ-017 While err==1, a blink counter SHALL count to BLINK_DIV-1, then toggle blink phase and return to 0.
REQ-018 While err==0, the blink counter SHALL be 0 and blink phase SHALL be 1.
REQ-019 The data field SHALL be forced to 0 whenever blink phase==0.
REQ-020 LEDR SHALL be registered, with one-cycle latency from inputs.
REQ-021 The value loaded into LEDR at an edge SHALL use that edge's inputs and the post-update page and blink phase.
REQ-022 A state change SHALL therefore show page 0 on the same edge it is detected.

Reset
REQ-023 While rst_n==0 at a clock edge, every register SHALL load its reset value:
- LEDR = 0;
- state_q = 00;
- page = 0;
- page timer = 0;
- blink counter = 0;
- blink phase = 1;
- prev_page_next = 0.
REQ-024 Reset SHALL override all other activity, including mid-page and mid-blink.
REQ-025 The first edge with rst_n==1 SHALL display current inputs at page 0.

Verification
Bench settings: DATA_W=8, LED_W=10 (DF=6, NPAGES=2), PAGE_DIV=4, BLINK_DIV=2.
REQ-026 Reset: rst_n low 3 cycles, all inputs nonzero -> LEDR=0. Release with state=00, OP=101, err=0 -> LEDR=0x051.
REQ-027 Manual paging: state=01, A=8'hB7, auto_page=0 -> 0x372. One page_next pulse -> 0x022. Second pulse wraps -> 0x372. page_next held high gives no further advance.
REQ-028 Auto paging: state=10, B=8'hC0, auto_page=1 -> 0x004 for 4 cycles, then 0x034 for 4 cycles, then 0x004. A page_next edge on an expiry cycle gives a single advance only.
REQ-029 State change on page 1: state 10 -> 11 with result=8'h3F -> LEDR=0x3F8 on the detecting edge; the page timer restarts.
REQ-030 Blink: state=11, result=8'h3F, err=1 -> LEDR alternates 0x3F8 x2 cycles, 0x008 x2 cycles. err low -> steady 0x3F8 next edge.
REQ-031 Reset mid-operation: rst_n low while on page 1 with blink phase 0 -> LEDR=0 next edge. Release -> page 0, blink phase 1.
